instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter, drives a byte address to the combinational instruction memory, and captures the returned 32-bit little-endian word into a 2-entry fetch buffer. It presents fetched instructions to decode through a valid/ready handshake, and supports redirects from branches or jumps and halt on a misaligned redirect.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
ADDR_W, 64, width of PC and instruction address
BUF_DEPTH, 2, fetch buffer entries; fixed at 2, other values unsupported

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
Inst_Address  output  64  byte address to instruction memory; equals pc register
Instruction  input  32  memory read data; valid in the same cycle as Inst_Address (combinational memory)
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts the head this cycle
out_instruction  output  32  buffer head instruction
out_pc  output  64  address the head instruction was fetched from
redirect_valid  input  1  replace pc with redirect_pc and flush buffer
redirect_pc  input  64  redirect target
fetch_fault  output  1  sticky flag for a misaligned redirect target

Behaviour:
- Reset, sampled on clk edge: pc=RESET_PC, buffer empty, state=RUN, out_valid=0, out_instruction=0, out_pc=0, fetch_fault=0. Reset has priority over every other input, including in-flight redirects and a full buffer.
- States:
  - RUN: fetching.
  - HALT: fetching stopped; pc frozen; buffer drains normally through out_ready.
  - HALT is left only via reset.
- Fetch in RUN, each cycle:
  - push = !full || (out_valid && out_ready).
  - On push: write {Instruction, pc} to buffer tail; pc <= pc + 4.
  - Otherwise hold pc.
  - PC arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: a word fetched in cycle N appears at the head (out_valid=1) in cycle N+1 if the buffer was empty. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Handshake:
  - Pop occurs when out_valid && out_ready.
  - out_instruction and out_pc are stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a pop, except on redirect or reset.
  - out_instruction and out_pc are driven from the head entry regardless of out_valid.
- Simultaneous push and pop while full: both occur and count stays 2. Push and pop while empty: not possible, since head is invalid.
- Redirect (redirect_valid=1 in RUN), with priority over push and pop in the same cycle:
  - Buffer is flushed (count=0), so out_valid=0 next cycle.
  - The concurrent fetch is discarded.
  - If redirect_pc[1:0]==0: pc <= redirect_pc and stay in RUN; the first instruction from the target is visible 2 cycles after the redirect cycle.
  - If redirect_pc[1:0]!=0: pc unchanged, fetch_fault <= 1, state <= HALT.
- Redirect in HALT: ignored.
- fetch_fault stays high until reset.
- Buffer: 2-entry circular, 1-bit read and write pointers plus a 2-bit count. Pointers wrap 1 to 0.

Decomposition:
- Shared package riscv_pkg holds:
  - ADDR_W
  - INST_W=32
  - INST_BYTES=4
  - fetch state enum {RUN, HALT}
  - fetch-entry struct {inst[31:0], pc[63:0]}
- One natural sub-module: fetch_buffer, a 2-entry synchronous FIFO with push/pop/flush, full/empty, head data, and synchronous active-high reset.
- PC and FSM logic stay in instruction_fetch_unit.

Test Plan:
- Memory image 0x02853483@0, 0x009a84b3@4, 0x00148493@8, 0x02953423@12. Reset, then out_ready=1 constantly -> first out_valid 1 cycle after reset release with out_instruction=0x02853483, out_pc=0; the next three cycles give 0x009a84b3/4, 0x00148493/8, 0x02953423/12.
- Backpressure, same image: out_ready=0 for 5 cycles after reset -> buffer fills with PCs 0 and 4; Inst_Address holds at 8; head stays 0x02853483/0. Release out_ready -> PCs 0, 4, 8 delivered in order with no loss or duplication.
- Full buffer with out_ready=1 in the same cycle -> pop of PC 0 and push of PC 8 together; count stays 2.
- Redirect to 64'h4 while the buffer holds PCs 8 and 12 and out_ready=1 -> next cycle out_valid=0 and Inst_Address=4; the following cycle out_pc=4 with 0x009a84b3. No instructions from PC 8 or 12 are delivered after the redirect.
- Redirect to 64'h6 -> fetch_fault=1 next cycle and stays high; Inst_Address frozen; buffer is flushed; later redirect_valid pulses are ignored; reset clears fault and restarts at RESET_PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> Inst_Address sequence FFF8, FFFC, 0, 4; asserting reset mid-stream with out_valid=1 -> out_valid=0 and pc=RESET_PC on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;

    localparam int ADDR_W     = 64;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry circular FIFO holding fetched {instruction, pc} pairs.
// Flush empties the FIFO and wins over push and pop in the same cycle.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head_entry
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    assign full       = (count_q == 2'd2);
    assign empty      = (count_q == 2'd0);
    assign head_entry = entry_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a push into a full
    // buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                entry_d[wr_ptr_q] = push_entry;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Register update; reset clears the entries so the head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the pc, reads a combinational
// instruction memory and hands words to decode via valid/ready.
// A misaligned redirect target halts fetching until reset.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] Inst_Address,
    input  logic [INST_W-1:0] Instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_instruction,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_fault
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              push;
    logic              pop;
    logic              flush;
    logic              buf_full;
    logic              buf_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign Inst_Address    = pc_q;
    assign fetch_fault     = fault_q;
    assign out_valid       = !buf_empty;
    assign out_instruction = head_entry.inst;
    assign out_pc          = head_entry.pc;
    assign pop             = out_valid && out_ready;
    assign push_entry      = '{inst: Instruction, pc: pc_q};

    // Fetch control: a redirect in RUN flushes and discards this cycle's
    // fetch; otherwise fetch whenever the buffer has (or is making) room.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                flush = 1'b1;
                if (redirect_pc[1:0] == 2'b00) begin
                    pc_d = redirect_pc;
                end else begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
            end else if (!buf_full || pop) begin
                push = 1'b1;
                pc_d = pc_q + ADDR_W'(INST_BYTES);
            end
        end
    end

    // State, pc and sticky fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_entry (head_entry)
    );

endmodule
